// File: rtl/flex_down_counter.sv
// flex_down_counter: loadable down-counter/timer with a one-cycle expiry pulse.
//
// A controller loads a start value. While in RUN, each cycle with count_enable
// subtracts DECREMENT_SIZE. When the count reaches zero, the counter saturates
// there instead of wrapping, and it raises expire_pulse for exactly one cycle.
// The pulse coincides with the first cycle that count_out reads zero.
//
// Priority on every rising edge: rst > clear > load > count_enable.
//
// Optional feature, enabled with the macro FLEX_DOWN_COUNTER_AUTO_RELOAD_EN:
//   - Every accepted load also writes a reload register.
//   - On a terminal decrement the counter reloads from that register and stays
//     in RUN, which makes it a periodic timer. It still pulses expire_pulse.
//   - Only rst, clear, or a load of zero stops it.
//   - In this build the DONE state is never entered.
//
// Handshake: there is no valid/ready pair. load and count_enable are
// single-cycle qualifiers sampled on the rising edge. expire_pulse is a
// registered strobe that the consumer must take on the cycle it is high;
// nothing holds it for the consumer.
//
// dbg_state_o exposes the FSM state for checkers:
//   2'd0 = IDLE, 2'd1 = RUN, 2'd2 = DONE.
//
// DECREMENT_SIZE must lie in the range 1 .. 2**SIZE-1.
module flex_down_counter #(
  parameter int SIZE           = 4,
  parameter int DECREMENT_SIZE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            load,
  input  logic [SIZE-1:0] load_val,
  input  logic            count_enable,
  output logic [SIZE-1:0] count_out,
  output logic            busy,
  output logic            expire_pulse,
  output logic [1:0]      dbg_state_o
);

  // Step size at the counter width, so that comparisons and subtraction
  // stay width-matched.
  localparam logic [SIZE-1:0] DEC = SIZE'(DECREMENT_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [SIZE-1:0] count_q, count_d;
  logic            busy_q, busy_d;
  logic            pulse_q, pulse_d;
  logic            at_terminal;

`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
  logic [SIZE-1:0] reload_q, reload_d;
`endif

  // The next decrement would reach or pass zero, so it saturates at zero
  // (or reloads, in the auto-reload build).
  assign at_terminal = (count_q <= DEC);

  // Next-state and next-output logic. Every target gets a hold value or a
  // zero pulse first, then the priority chain overrides it.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pulse_d = 1'b0;
`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (clear) begin
      count_d = '0;
      state_d = ST_IDLE;
    end else if (load) begin
      // A load overrides any decrement on the same edge, including a
      // terminal one, so it never produces an expiry pulse.
`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
      reload_d = load_val;
`endif
      if (load_val != '0) begin
        count_d = load_val;
        state_d = ST_RUN;
      end else begin
        count_d = '0;
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          // count_enable is ignored while idle.
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (count_enable) begin
            if (!at_terminal) begin
              count_d = count_q - DEC;
            end else begin
              pulse_d = 1'b1;
`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
              count_d = reload_q;
              state_d = ST_RUN;
`else
              count_d = '0;
              state_d = ST_DONE;
`endif
            end
          end
        end
        ST_DONE: begin
          // DONE lasts a single cycle; the pulse drops on this exit edge.
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    // busy is a registered decode of the state being entered.
    busy_d = (state_d == ST_RUN);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      pulse_q <= pulse_d;
    end
  end

`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
  // Reload register; it holds the value of the last accepted load.
  always_ff @(posedge clk) begin
    if (rst) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  assign count_out    = count_q;
  assign busy         = busy_q;
  assign expire_pulse = pulse_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_flex_down_counter.sv
// tb_flex_down_counter: two counters (decrement 1 and 2) driven by the same
// stimulus and checked every cycle against a behavioural timer model.
module tb_flex_down_counter;

  // Clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic       count_enable = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] cnt_a, cnt_b;
  logic       busy_a, busy_b, pulse_a, pulse_b;
  logic [1:0] st_a, st_b;

  int checks = 0;
  int errors = 0;

  flex_down_counter #(.SIZE(4), .DECREMENT_SIZE(1)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
    .count_enable(count_enable), .count_out(cnt_a), .busy(busy_a),
    .expire_pulse(pulse_a), .dbg_state_o(st_a)
  );

  flex_down_counter #(.SIZE(4), .DECREMENT_SIZE(2)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
    .count_enable(count_enable), .count_out(cnt_b), .busy(busy_b),
    .expire_pulse(pulse_b), .dbg_state_o(st_b)
  );

  // Reference model: a timer that is either stopped or running. It holds a
  // remaining count, and it notes whether a run ended on the last edge.
  int m_step[2] = '{1, 2};
  int m_left[2] = '{0, 0};
  bit m_running[2] = '{1'b0, 1'b0};
  bit m_expired[2] = '{1'b0, 1'b0};

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      m_expired[k] = 1'b0;
      if (rst || clear) begin
        m_left[k] = 0;
        m_running[k] = 1'b0;
      end else if (load) begin
        m_left[k] = int'(load_val);
        m_running[k] = (load_val != 0);
      end else if (m_running[k] && count_enable) begin
        m_left[k] = (m_left[k] > m_step[k]) ? m_left[k] - m_step[k] : 0;
        if (m_left[k] == 0) begin
          m_running[k] = 1'b0;
          m_expired[k] = 1'b1;
        end
      end
    end
  endtask

  // Scoreboard comparison
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] c[2];
    logic       b[2];
    logic       p[2];
    logic [1:0] s[2];
    int         exp_state;
    c[0] = cnt_a;  c[1] = cnt_b;
    b[0] = busy_a; b[1] = busy_b;
    p[0] = pulse_a; p[1] = pulse_b;
    s[0] = st_a;   s[1] = st_b;
    for (int k = 0; k < 2; k++) begin
      exp_state = m_running[k] ? 1 : (m_expired[k] ? 2 : 0);
      check_val($sformatf("%s/dec%0d/count", tag, m_step[k]), 32'(c[k]), 32'(m_left[k]));
      check_val($sformatf("%s/dec%0d/busy", tag, m_step[k]), 32'(b[k]), 32'(m_running[k]));
      check_val($sformatf("%s/dec%0d/expire", tag, m_step[k]), 32'(p[k]), 32'(m_expired[k]));
      check_val($sformatf("%s/dec%0d/state", tag, m_step[k]), 32'(s[k]), 32'(exp_state));
    end
  endtask

  // Driver: apply one cycle of inputs, advance the model on the edge, and
  // check 1 time unit after the edge.
  task automatic step(input bit r, input bit c, input bit l, input int v,
                      input bit e, input string tag);
    rst = r; clear = c; load = l; load_val = 4'(v); count_enable = e;
    @(posedge clk);
    model_update();
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset
    step(1, 0, 0, 0, 0, "reset");
    step(0, 0, 0, 0, 1, "idle_enable_ignored");

    // T1 basic: load 3, enable held high
    step(0, 0, 1, 3, 1, "t1_load");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, "t1_run");

    // T2 saturation: load 5, enable high (dec2 instance gives 5,3,1,0)
    step(0, 0, 1, 5, 1, "t2_load");
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, "t2_run");

    // T3 gaps: load 2, enable 1,0,0,1
    step(0, 0, 1, 2, 0, "t3_load");
    step(0, 0, 0, 0, 1, "t3_en1");
    step(0, 0, 0, 0, 0, "t3_gap1");
    step(0, 0, 0, 0, 0, "t3_gap2");
    step(0, 0, 0, 0, 1, "t3_en2");
    step(0, 0, 0, 0, 1, "t3_after");

    // T4 collision: load 9 on the terminal edge, then clear at count 4
    step(0, 0, 1, 2, 0, "t4_load2");
    step(0, 0, 0, 0, 1, "t4_to1");
    step(0, 0, 1, 9, 1, "t4_load_wins");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, "t4_down");
    step(0, 1, 0, 0, 1, "t4_clear");
    step(0, 0, 0, 0, 1, "t4_after_clear");

    // T5 zero load and reset mid-run
    step(0, 0, 1, 0, 1, "t5_load0");
    step(0, 0, 0, 0, 1, "t5_idle");
    step(0, 0, 1, 8, 1, "t5_load8");
    step(0, 0, 0, 0, 1, "t5_to7");
    step(0, 0, 0, 0, 1, "t5_to6");
    step(1, 0, 0, 0, 1, "t5_rst");

    // Load in RUN restarts, load in DONE behaves as in IDLE
    step(0, 0, 1, 1, 1, "ld1");
    step(0, 0, 0, 0, 1, "ld1_expire");
    step(0, 0, 1, 4, 1, "load_in_done");
    step(0, 0, 1, 15, 1, "load_in_run");
    step(0, 0, 1, 0, 1, "load0_in_run");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15)),
           ($urandom_range(0, 3) != 0),
           "random");
    end

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
